aes_encrypt_sequencer: RTL and testbench
========================================

# aes_encrypt_sequencer

Control block for iterative AES-128 encryption. It accepts key/plaintext blocks over a valid/ready handshake and sequences `key_creation`, driving `startTransition`/`roundKeyInput` and waiting a fixed latency. It feeds the expanded round keys, one per cycle, to an external combinational round unit and returns the ciphertext over a second valid/ready handshake. Expanded keys are cached, so consecutive blocks under the same key skip re-expansion.

## Interface
- `KEY_LATENCY`, default 12: cycles with `keyStart` high before round keys are valid.
- `clock` in 1: system clock (50 MHz).
- `reset_n` in 1: asynchronous reset, active-low.
- `inValid` in 1: input block valid.
- `inReady` out 1: sequencer can accept a block.
- `inKey` in 128: cipher key.
- `inData` in 128: plaintext.
- `keyStart` out 1: drives `key_creation.startTransition`.
- `keyOut` out 128: drives `key_creation.roundKeyInput`.
- `roundKeysIn` in 1408: `{roundKeyOutput10,…,roundKeyOutput0}`; key k is at bits [128k+127:128k].
- `rndState` out 128: current state to the round unit.
- `rndKey` out 128: round key for the current round.
- `rndFinal` out 1: final round, so the round unit omits MixColumns.
- `rndResult` in 128: round-unit output, combinational from `rndState`/`rndKey`/`rndFinal`.
- `outValid` out 1: ciphertext valid.
- `outReady` in 1: consumer accepts ciphertext.
- `outData` out 128: ciphertext.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, KEYDROP, KEYWAIT, ARK, ROUND, DONE.
- IDLE: `inReady`=1.
  - On `inValid`: latch `inData` into the state register.
  - Hit (`keyValid` && `inKey`==`keyOut`) → ARK.
  - Miss → latch `inKey` into `keyOut`, clear `keyValid`, → KEYDROP.
- KEYDROP: `keyStart`=0 for exactly one cycle, which guarantees a fresh rising edge. Wait counter cleared. → KEYWAIT.
- KEYWAIT: `keyStart`=1. Counter increments each cycle. At count KEY_LATENCY-1, set `keyValid` and go to ARK.
- `keyStart` stays 1 in every state except KEYDROP and reset, holding the expansion valid.
- ARK: state ← state ^ `roundKeysIn`[127:0]; round counter ← 1. → ROUND.
- ROUND: `rndState`=state, `rndKey`=key[round], `rndFinal`=(round==10).
  - Each cycle: state ← `rndResult`, round ← round+1.
  - Leave after round 10 → DONE.
- DONE: `outValid`=1 and `outData`=state, both held stable until `outReady`; then → IDLE.
- Round counter is 4 bits and is only ever used in the range 1..10; key index 0 is used only in ARK.
- `outData` and `outValid` are registered. `inReady` and `busy` are decoded from state.

## Timing
- Reset (asynchronous, `reset_n`=0):
  - state → IDLE; `keyValid`=0.
  - `keyStart`=0, `keyOut`=0, `outValid`=0, `outData`=0, `rndState`=0, `rndFinal`=0, `busy`=0, `inReady`=1.
- Latency from the accept edge to `outValid` high:
  - Key hit: 11 cycles (ARK, then 10 ROUND).
  - Key miss: 12 + KEY_LATENCY cycles (adds 1 KEYDROP cycle and KEY_LATENCY KEYWAIT cycles).
- `inReady` is low from the cycle after accept until the cycle after the output handshake; at most one block is in flight.
- Output handshake: same-cycle `outValid` && `outReady` completes the transfer. The next input can be accepted one cycle later.
- If `outReady` is held low, the block stalls indefinitely in DONE with `outData` unchanged.
- A different `inKey` presented while busy is ignored; only the key latched at accept is used.
- Reset asserted mid-operation aborts the block: no `outValid` is produced and `keyValid` is lost, so the next block always re-expands.
- `roundKeysIn` is treated as valid only when `keyValid`=1. Its values during KEYWAIT are ignored.

## Structure
- Shared package `aes_pkg`:
  - FSM state encoding.
  - `AES_ROUNDS`=10, `AES_BLOCK_W`=128, `AES_NUM_RKEYS`=11.
  - Default `KEY_LATENCY`.
- Sub-module `aes_keywait_counter`: a clearable up-counter with terminal-count output, used by KEYWAIT.
- The round unit and `key_creation` are instantiated by the parent, not inside this block.

## Test plan
Bench wires the real `key_creation` and a reference round unit.
1. Reset check: assert `reset_n`=0 → all outputs at their reset values, with `inReady`=1.
2. First block, cold key:
   - Stimulus: key 000102030405060708090a0b0c0d0e0f, data 00112233445566778899aabbccddeeff.
   - Required: `keyStart` low 1 cycle, then high; `outValid` exactly 12+KEY_LATENCY cycles after accept; `outData`=69c4e0d86a7b0430d8cdb78070b4c55a.
3. Second block, same key and data:
   - Required: no `keyStart` drop; `outValid` 11 cycles after accept; same ciphertext.
4. Output backpressure: hold `outReady`=0 for 5 cycles in DONE → `outData` stable, `inReady`=0, `busy`=1; the release cycle completes the transfer.
5. Key change: key and data all-zero → re-expansion occurs; `outData`=66e94bd4ef8a2c3b884cfa59ca342b2e.
6. Reset mid-operation: assert `reset_n` during KEYWAIT → no `outValid`; the next block with the same key takes the cold path (KEYDROP seen) and returns the correct ciphertext.

Source files
------------

// File: rtl/aes_encrypt_sequencer_pkg.sv
// aes_pkg: shared AES sequencer constants and FSM state encoding
package aes_pkg;
    typedef enum logic [2:0] {IDLE, KEYDROP, KEYWAIT, ARK, ROUND, DONE} state_t;
    localparam int AES_ROUNDS = 10;
    localparam int AES_BLOCK_W = 128;
    localparam int AES_NUM_RKEYS = 11;
    localparam int DEFAULT_KEY_LATENCY = 12;
endpackage

// File: rtl/aes_keywait_counter.sv
// aes_keywait_counter: clearable up-counter flagging LIMIT-1 as terminal count
module aes_keywait_counter #(
    parameter int LIMIT = 12
) (
    input  logic clock,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    localparam int W = $clog2(LIMIT + 1);
    logic [W-1:0] count;
    assign tc = count == W'(LIMIT - 1);
    // count key-expansion wait cycles, restarting on clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) count <= '0;
        else if (clear) count <= '0;
        else if (enable) count <= count + 1'b1;
    end
endmodule

// File: rtl/aes_encrypt_sequencer.sv
// aes_encrypt_sequencer: iterative AES-128 control with cached key expansion
module aes_encrypt_sequencer
    import aes_pkg::*;
#(
    parameter int KEY_LATENCY = DEFAULT_KEY_LATENCY
) (
    input  logic                                 clock,
    input  logic                                 reset_n,
    input  logic                                 inValid,
    output logic                                 inReady,
    input  logic [AES_BLOCK_W-1:0]               inKey,
    input  logic [AES_BLOCK_W-1:0]               inData,
    output logic                                 keyStart,
    output logic [AES_BLOCK_W-1:0]               keyOut,
    input  logic [AES_NUM_RKEYS*AES_BLOCK_W-1:0] roundKeysIn,
    output logic [AES_BLOCK_W-1:0]               rndState,
    output logic [AES_BLOCK_W-1:0]               rndKey,
    output logic                                 rndFinal,
    input  logic [AES_BLOCK_W-1:0]               rndResult,
    output logic                                 outValid,
    input  logic                                 outReady,
    output logic [AES_BLOCK_W-1:0]               outData,
    output logic                                 busy
);
    localparam logic [3:0] LAST = 4'(AES_ROUNDS);
    state_t st, st_nx;
    logic key_valid, hit, tc;
    logic [3:0] round, kidx;
    logic [AES_BLOCK_W-1:0] blk;
    logic [AES_BLOCK_W-1:0] rkeys [AES_NUM_RKEYS];
    for (genvar k = 0; k < AES_NUM_RKEYS; k++) begin : g_rk
        assign rkeys[k] = roundKeysIn[k*AES_BLOCK_W +: AES_BLOCK_W];
    end
    aes_keywait_counter #(.LIMIT(KEY_LATENCY)) u_wait (
        .clock(clock),
        .reset_n(reset_n),
        .clear(st == KEYDROP),
        .enable(st == KEYWAIT),
        .tc(tc)
    );
    assign hit = key_valid && inKey == keyOut;
    assign inReady = st == IDLE;
    assign busy = st != IDLE;
    assign rndState = blk;
    assign rndFinal = st == ROUND && round == LAST;
    assign kidx = round > LAST ? 4'd0 : round;
    assign rndKey = rkeys[kidx];
    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) st <= IDLE;
        else st <= st_nx;
    end
    // next-state decode
    always_comb begin
        st_nx = st;
        case (st)
            IDLE:    st_nx = inValid ? (hit ? ARK : KEYDROP) : IDLE;
            KEYDROP: st_nx = KEYWAIT;
            KEYWAIT: st_nx = tc ? ARK : KEYWAIT;
            ARK:     st_nx = ROUND;
            ROUND:   st_nx = round == LAST ? DONE : ROUND;
            DONE:    st_nx = outReady ? IDLE : DONE;
            default: st_nx = IDLE;
        endcase
    end
    // datapath: key cache, AES state, round count and registered output
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            keyStart <= 1'b0;
            keyOut <= '0;
            key_valid <= 1'b0;
            blk <= '0;
            round <= '0;
            outValid <= 1'b0;
            outData <= '0;
        end else begin
            keyStart <= st_nx != KEYDROP;
            case (st)
                IDLE: if (inValid) begin
                    blk <= inData;
                    if (!hit) begin
                        keyOut <= inKey;
                        key_valid <= 1'b0;
                    end
                end
                KEYWAIT: if (tc) key_valid <= 1'b1;
                ARK: begin
                    blk <= blk ^ rkeys[0];
                    round <= 4'd1;
                end
                ROUND: begin
                    blk <= rndResult;
                    if (round == LAST) begin
                        outValid <= 1'b1;
                        outData <= rndResult;
                    end else round <= round + 1'b1;
                end
                DONE: if (outReady) outValid <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_encrypt_sequencer.sv
// tb_aes_encrypt_sequencer: directed plus random blocks against a behavioural AES model
module tb_aes_encrypt_sequencer;
    localparam int L = 12;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic inValid = 1'b0, inReady, keyStart, rndFinal, outValid, outReady = 1'b1, busy;
    logic [127:0] inKey = '0, inData = '0, keyOut, rndState, rndKey, rndResult, outData;
    logic [1407:0] roundKeysIn, garbage = '0;
    int kc_cnt = 0;
    int checks = 0, errors = 0;
    logic [127:0] cache_key = '0;
    bit cache_valid = 0;
    logic [127:0] pool [3];

    aes_encrypt_sequencer #(.KEY_LATENCY(L)) dut (
        .clock(clock), .reset_n(reset_n), .inValid(inValid), .inReady(inReady),
        .inKey(inKey), .inData(inData), .keyStart(keyStart), .keyOut(keyOut),
        .roundKeysIn(roundKeysIn), .rndState(rndState), .rndKey(rndKey),
        .rndFinal(rndFinal), .rndResult(rndResult), .outValid(outValid),
        .outReady(outReady), .outData(outData), .busy(busy)
    );

    always #10 clock = ~clock;

    function automatic logic [7:0] xt(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) r = r ^ a;
            a = xt(a);
            b = b >> 1;
        end
        return r;
    endfunction

    // S-box as GF(2^8) inverse (b^254) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [7:0] p = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            p = gmul(p, p);
            if (i != 0) p = gmul(p, b);
        end
        return p ^ {p[6:0], p[7]} ^ {p[5:0], p[7:6]} ^ {p[4:0], p[7:5]} ^ {p[3:0], p[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0] a [16];
        logic [7:0] t [16];
        logic [127:0] r;
        for (int i = 0; i < 16; i++) a[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int w = 0; w < 4; w++) t[4*c+w] = a[4*((c+w)%4)+w];
        for (int c = 0; c < 4; c++) begin
            a[4*c]   = fin ? t[4*c]   : xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1] ^ t[4*c+2] ^ t[4*c+3];
            a[4*c+1] = fin ? t[4*c+1] : t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2]) ^ t[4*c+2] ^ t[4*c+3];
            a[4*c+2] = fin ? t[4*c+2] : t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2]) ^ xt(t[4*c+3]) ^ t[4*c+3];
            a[4*c+3] = fin ? t[4*c+3] : xt(t[4*c]) ^ t[4*c] ^ t[4*c+1] ^ t[4*c+2] ^ xt(t[4*c+3]);
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = a[i];
        return r ^ k;
    endfunction

    function automatic logic [1407:0] expand(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0] rc = 8'h01;
        logic [1407:0] r;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
                rc = xt(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int k = 0; k < 11; k++) r[128*k +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return r;
    endfunction

    function automatic logic [127:0] aes_encrypt(input logic [127:0] key, input logic [127:0] pt);
        logic [1407:0] rk = expand(key);
        logic [127:0] s = pt ^ rk[127:0];
        for (int r = 1; r < 10; r++) s = aes_round(s, rk[128*r +: 128], 1'b0);
        return aes_round(s, rk[1280 +: 128], 1'b1);
    endfunction

    // key_creation stand-in: keys valid only after L cycles of keyStart high, noise otherwise
    always @(posedge clock) begin
        kc_cnt <= keyStart ? kc_cnt + 1 : 0;
        for (int i = 0; i < 44; i++) garbage[32*i +: 32] <= $urandom;
    end

    // key expansion output mux
    always_comb roundKeysIn = (kc_cnt >= L) ? expand(keyOut) : garbage;

    // combinational reference round unit
    always_comb rndResult = aes_round(rndState, rndKey, rndFinal);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_block(input logic [127:0] key, input logic [127:0] data, input int hold, input logic [127:0] exp);
        bit hit;
        int n, drops;
        hit = cache_valid && key == cache_key;
        @(negedge clock);
        chk("in_ready_idle", 128'(inReady), 128'd1);
        inValid = 1'b1;
        inKey = key;
        inData = data;
        outReady = hold == 0;
        @(posedge clock);
        #1 inValid = 1'b0;
        inKey = {$urandom, $urandom, $urandom, $urandom};
        inData = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        drops = int'(!keyStart);
        n = 0;
        while (!outValid && n < 200) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (!outValid && !keyStart) drops++;
        end
        cache_key = key;
        cache_valid = 1;
        chk("latency", 128'(n), hit ? 128'd11 : 128'(12 + L));
        chk("keystart_drops", 128'(drops), hit ? 128'd0 : 128'd1);
        chk("out_data", outData, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            chk("stall_valid", 128'(outValid), 128'd1);
            chk("stall_data", outData, exp);
            chk("stall_in_ready", 128'(inReady), 128'd0);
            chk("stall_busy", 128'(busy), 128'd1);
        end
        outReady = 1'b1;
        @(posedge clock);
        @(negedge clock);
        chk("post_valid", 128'(outValid), 128'd0);
        chk("post_in_ready", 128'(inReady), 128'd1);
    endtask

    // directed sequence followed by randomized blocks over a small key pool
    initial begin
        logic [127:0] k, d;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_keystart", 128'(keyStart), 128'd0);
        chk("rst_keyout", keyOut, 128'd0);
        chk("rst_outvalid", 128'(outValid), 128'd0);
        chk("rst_outdata", outData, 128'd0);
        chk("rst_rndstate", rndState, 128'd0);
        chk("rst_rndfinal", 128'(rndFinal), 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_inready", 128'(inReady), 128'd1);
        reset_n = 1'b1;
        run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 0,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 0,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_block(128'h000102030405060708090a0b0c0d0e0f, 128'h00112233445566778899aabbccddeeff, 5,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        run_block(128'h0, 128'h0, 0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e);
        k = {$urandom, $urandom, $urandom, $urandom};
        d = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clock);
        inValid = 1'b1;
        inKey = k;
        inData = d;
        @(posedge clock);
        #1 inValid = 1'b0;
        repeat (5) @(posedge clock);
        #3 reset_n = 1'b0;
        #1;
        chk("midrst_outvalid", 128'(outValid), 128'd0);
        chk("midrst_busy", 128'(busy), 128'd0);
        chk("midrst_keystart", 128'(keyStart), 128'd0);
        chk("midrst_keyout", keyOut, 128'd0);
        cache_valid = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("midrst_hold_outvalid", 128'(outValid), 128'd0);
        end
        reset_n = 1'b1;
        run_block(k, d, 0, aes_encrypt(k, d));
        for (int i = 0; i < 3; i++) pool[i] = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 12; i++) begin
            k = pool[$urandom_range(0, 2)];
            d = {$urandom, $urandom, $urandom, $urandom};
            run_block(k, d, $urandom_range(0, 3), aes_encrypt(k, d));
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
